// File: rtl/sma_mch_pow2_if.sv
// Sample/result bus of the multi-channel power-of-two moving average.
//   win_sel      : window exponent request (N = 2^win_sel)
//   sample_valid : sample strobe, taken only while busy is low
//   sample_ch    : channel tag of the sample
//   sample_data  : signed sample
//   busy         : high while the block cannot take a sample this cycle
//   result_valid : one-cycle pulse, result fields below are fresh
//   result_ch    : channel of the result
//   result_data  : signed floor average
//   result_full  : channel held at least N samples since the last clear
interface sma_mch_pow2_if #(
    parameter int DATA_W = 32,
    parameter int NCH    = 4
);
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic        [4:0]        win_sel;
    logic                     sample_valid;
    logic        [CH_W-1:0]   sample_ch;
    logic signed [DATA_W-1:0] sample_data;
    logic                     busy;
    logic                     result_valid;
    logic        [CH_W-1:0]   result_ch;
    logic signed [DATA_W-1:0] result_data;
    logic                     result_full;

    modport master (
        output win_sel, sample_valid, sample_ch, sample_data,
        input  busy, result_valid, result_ch, result_data, result_full
    );

    modport slave (
        input  win_sel, sample_valid, sample_ch, sample_data,
        output busy, result_valid, result_ch, result_data, result_full
    );
endinterface

// File: rtl/sma_mch_pow2.sv
// Multi-channel, run-time-selectable power-of-two simple moving average.
// NCH channels share one circular sample RAM addressed by {channel, ptr}.
// Result = floor(sum of last N samples / N), N = 2^win. A change of the
// window clears every channel's history.
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset
//   bus     : sample input / result output bundle (slave side)
module sma_mch_pow2 #(
    parameter int DATA_W   = 32,
    parameter int MAX_LOG2 = 15,
    parameter int NCH      = 4
) (
    input logic           i_clk,
    input logic           i_rst_n,
    sma_mch_pow2_if.slave bus
);
    localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int SUM_W  = DATA_W + MAX_LOG2;
    localparam int PTR_W  = (MAX_LOG2 > 0) ? MAX_LOG2 : 1;
    localparam int FILL_W = MAX_LOG2 + 1;
    localparam int ADDR_W = CH_W + PTR_W;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef enum logic [2:0] {S_CLR, S_IDLE, S_RD, S_ACC, S_OUT} state_t;

    function automatic logic [4:0] clamp_win(input logic [4:0] sel);
        if (int'(sel) > MAX_LOG2) return 5'(MAX_LOG2);
        return sel;
    endfunction

    function automatic logic signed [SUM_W-1:0] sext(input logic signed [DATA_W-1:0] v);
        return SUM_W'(v);
    endfunction

    // Arithmetic shift gives floor division for negative sums too.
    function automatic logic signed [DATA_W-1:0] avg_floor(input logic signed [SUM_W-1:0] s,
                                                           input logic [4:0] w);
        logic signed [SUM_W-1:0] sh;
        sh = s >>> w;
        return sh[DATA_W-1:0];
    endfunction

    state_t                   state;
    logic        [4:0]        win_r;
    logic                     busy_r;
    logic                     res_valid;
    logic        [CH_W-1:0]   res_ch;
    logic signed [DATA_W-1:0] res_data;
    logic                     res_full;

    logic signed [SUM_W-1:0]  sum_r  [NCH];
    logic        [PTR_W-1:0]  ptr_r  [NCH];
    logic        [FILL_W-1:0] fill_r [NCH];

    logic signed [DATA_W-1:0] ram [DEPTH];
    logic signed [DATA_W-1:0] ram_q_p1;
    logic        [CH_W-1:0]   ch_p0;
    logic signed [DATA_W-1:0] data_p0;

    logic        [4:0]        win_new;
    logic                     win_chg;
    logic        [FILL_W-1:0] n_val;
    logic [(1<<CH_W)-1:0]     ch_en;
    logic                     rd_en;
    logic        [ADDR_W-1:0] rd_addr;
    logic                     wr_en;
    logic        [ADDR_W-1:0] wr_addr;

    logic signed [SUM_W-1:0]  cur_sum;
    logic        [PTR_W-1:0]  cur_ptr;
    logic        [FILL_W-1:0] cur_fill;
    logic                     is_full;
    logic signed [DATA_W-1:0] old;
    logic signed [SUM_W-1:0]  sum_nxt;
    logic        [PTR_W-1:0]  ptr_nxt;
    logic        [FILL_W-1:0] fill_nxt;
    logic                     full_nxt;

    assign win_new = clamp_win(bus.win_sel);
    assign win_chg = (win_new != win_r);
    assign n_val   = FILL_W'(1) << win_r;

    // Tags at or above NCH are not channels and must never be accepted.
    always_comb begin
        ch_en = '0;
        for (int i = 0; i < (1 << CH_W); i++) ch_en[i] = (i < NCH);
    end

    assign rd_en   = (state == S_IDLE) && !win_chg && bus.sample_valid && ch_en[bus.sample_ch];
    assign rd_addr = {bus.sample_ch, ptr_r[bus.sample_ch]};

    always_comb begin
        cur_sum  = sum_r[ch_p0];
        cur_ptr  = ptr_r[ch_p0];
        cur_fill = fill_r[ch_p0];
        is_full  = (cur_fill == n_val);
        // Until the window is full the slot being overwritten holds stale data.
        old      = is_full ? ram_q_p1 : '0;
        sum_nxt  = cur_sum + sext(data_p0) - sext(old);
        ptr_nxt  = (FILL_W'(cur_ptr) == n_val - 1'b1) ? '0 : cur_ptr + 1'b1;
        fill_nxt = is_full ? cur_fill : cur_fill + 1'b1;
        full_nxt = (fill_nxt == n_val);
        wr_en    = (state == S_ACC) && !win_chg;
        wr_addr  = {ch_p0, cur_ptr};
    end

    // ---- p0: accepted sample latched, RAM read issued ----
    always_ff @(posedge i_clk) begin
        if (rd_en) begin
            ch_p0    <= bus.sample_ch;
            data_p0  <= bus.sample_data;
            ram_q_p1 <= ram[rd_addr];
        end
        if (wr_en) ram[wr_addr] <= data_p0;
    end

    // ---- p1/p2: accumulate, then present result ----
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= S_CLR;
            win_r     <= '0;
            busy_r    <= 1'b0;
            res_valid <= 1'b0;
            res_ch    <= '0;
            res_data  <= '0;
            res_full  <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                sum_r[i]  <= '0;
                ptr_r[i]  <= '0;
                fill_r[i] <= '0;
            end
        end else begin
            win_r     <= win_new;
            res_valid <= 1'b0;
            case (state)
                S_CLR: begin
                    for (int i = 0; i < NCH; i++) begin
                        sum_r[i]  <= '0;
                        ptr_r[i]  <= '0;
                        fill_r[i] <= '0;
                    end
                    state  <= S_IDLE;
                    busy_r <= 1'b0;
                end
                S_IDLE: begin
                    if (win_chg) begin
                        state  <= S_CLR;
                        busy_r <= 1'b1;
                    end else if (rd_en) begin
                        state  <= S_RD;
                        busy_r <= 1'b1;
                    end
                end
                S_RD: begin
                    state <= win_chg ? S_CLR : S_ACC;
                end
                S_ACC: begin
                    if (win_chg) begin
                        state <= S_CLR;
                    end else begin
                        sum_r[ch_p0]  <= sum_nxt;
                        ptr_r[ch_p0]  <= ptr_nxt;
                        fill_r[ch_p0] <= fill_nxt;
                        res_valid     <= 1'b1;
                        res_ch        <= ch_p0;
                        res_data      <= avg_floor(sum_nxt, win_r);
                        res_full      <= full_nxt;
                        state         <= S_OUT;
                    end
                end
                S_OUT: begin
                    state  <= win_chg ? S_CLR : S_IDLE;
                    busy_r <= win_chg;
                end
                default: begin
                    state  <= S_CLR;
                    busy_r <= 1'b1;
                end
            endcase
        end
    end

    assign bus.busy         = busy_r;
    assign bus.result_valid = res_valid;
    assign bus.result_ch    = res_ch;
    assign bus.result_data  = res_data;
    assign bus.result_full  = res_full;
endmodule

// File: tb/tb_sma_mch_pow2.sv
// Directed bench for sma_mch_pow2 (DATA_W=32, MAX_LOG2=6, NCH=3 so that
// channel tag 3 is representable but invalid).
module tb_sma_mch_pow2;
    localparam int DATA_W   = 32;
    localparam int MAX_LOG2 = 6;
    localparam int NCH      = 3;
    localparam longint MAXV = 64'sd2147483647;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    sma_mch_pow2_if #(.DATA_W(DATA_W), .NCH(NCH)) bus ();

    sma_mch_pow2 #(.DATA_W(DATA_W), .MAX_LOG2(MAX_LOG2), .NCH(NCH)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_win(input int w);
        bus.win_sel = 5'(w);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Sends one sample and checks latency, busy and the result fields.
    task automatic send(input int c, input int d, input int ed, input logic ef, input string tag);
        int k;
        k = 0;
        while (bus.busy === 1'b1 && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk({tag, "_ready"}, (k < 20), 1);
        bus.sample_valid = 1'b1;
        bus.sample_ch    = 2'(c);
        bus.sample_data  = d;
        @(posedge clk);
        #1;
        bus.sample_valid = 1'b0;
        chk({tag, "_busy"}, bus.busy, 1);
        chk({tag, "_early"}, bus.result_valid, 0);
        @(posedge clk);
        #1;
        chk({tag, "_early2"}, bus.result_valid, 0);
        @(posedge clk);
        #1;
        chk({tag, "_valid"}, bus.result_valid, 1);
        chk({tag, "_ch"}, bus.result_ch, c);
        chk({tag, "_data"}, bus.result_data, ed);
        chk({tag, "_full"}, bus.result_full, ef);
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, bus.result_valid, 0);
    endtask

    initial begin
        int     cnt;
        int     bcnt;
        longint s;
        checks = 0;
        errors = 0;
        rst_n            = 1'b0;
        bus.win_sel      = 5'd2;
        bus.sample_valid = 1'b0;
        bus.sample_ch    = '0;
        bus.sample_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_valid", bus.result_valid, 0);
        chk("rst_ch", bus.result_ch, 0);
        chk("rst_data", bus.result_data, 0);
        chk("rst_full", bus.result_full, 0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // T1: window 4 on channel 0
        send(0, 4, 1, 0, "t1_s1");
        send(0, 8, 3, 0, "t1_s2");
        send(0, 12, 6, 0, "t1_s3");
        send(0, 16, 10, 1, "t1_s4");
        send(0, 20, 14, 1, "t1_s5");

        // T2: window 1 then window 4 with negative floor
        set_win(0);
        send(1, -5, -5, 1, "t2_a1");
        send(1, 7, 7, 1, "t2_a2");
        set_win(2);
        send(1, -1, -1, 0, "t2_b1");
        send(1, -2, -1, 0, "t2_b2");
        send(1, 0, -1, 0, "t2_b3");
        send(1, 0, -1, 1, "t2_b4");

        // T3: interleaved channels are independent
        set_win(1);
        send(0, 100, 50, 0, "t3_c0a");
        send(1, -100, -50, 0, "t3_c1a");
        send(0, 300, 200, 1, "t3_c0b");
        send(1, -300, -200, 1, "t3_c1b");

        // T4: window change while a sample is in RD
        set_win(3);
        for (int k = 1; k <= 8; k++) send(0, 1000, 125 * k, (k == 8), $sformatf("t4_fill%0d", k));
        bus.sample_valid = 1'b1;
        bus.sample_ch    = 2'd0;
        bus.sample_data  = 5;
        @(posedge clk);
        #1;
        bus.sample_valid = 1'b0;
        chk("t4_rd_busy", bus.busy, 1);
        bus.win_sel = 5'd1;
        @(posedge clk);
        #1;
        chk("t4_clr_busy", bus.busy, 1);
        @(posedge clk);
        #1;
        chk("t4_idle_busy", bus.busy, 0);
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            if (bus.result_valid === 1'b1) cnt++;
            @(posedge clk);
            #1;
        end
        chk("t4_no_valid", cnt, 0);
        send(0, 2, 1, 0, "t4_n1");
        send(0, 4, 3, 1, "t4_n2");

        // T5: largest window, full-scale samples, pointer wrap
        set_win(31);
        for (int k = 1; k <= 67; k++) begin
            s = (k <= 64) ? k * MAXV : 64 * MAXV;
            send(2, int'(MAXV), int'(s >>> 6), (k >= 64), $sformatf("t5_p%0d", k));
        end
        for (int j = 1; j <= 67; j++) begin
            s = (j <= 64) ? (64 - 2 * j) * MAXV : -64 * MAXV;
            send(2, -int'(MAXV), int'(s >>> 6), 1, $sformatf("t5_n%0d", j));
        end

        // T6: valid held high, then an invalid channel tag
        set_win(0);
        cnt = 0;
        bus.sample_valid = 1'b1;
        bus.sample_ch    = 2'd0;
        bus.sample_data  = 9;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            #1;
            if (bus.result_valid === 1'b1) begin
                cnt++;
                chk("t6_data", bus.result_data, 9);
            end
        end
        bus.sample_valid = 1'b0;
        chk("t6_accepts", cnt, 4);
        cnt  = 0;
        bcnt = 0;
        bus.sample_valid = 1'b1;
        bus.sample_ch    = 2'd3;
        bus.sample_data  = 77;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (bus.result_valid === 1'b1) cnt++;
            if (bus.busy === 1'b1) bcnt++;
        end
        bus.sample_valid = 1'b0;
        chk("t6_bad_ch_valid", cnt, 0);
        chk("t6_bad_ch_busy", bcnt, 0);
        send(0, 11, 11, 1, "t6_after");

        // Asynchronous reset mid-operation clears history
        set_win(2);
        send(0, 40, 10, 0, "ar_pre");
        bus.sample_valid = 1'b1;
        bus.sample_ch    = 2'd0;
        bus.sample_data  = 40;
        @(posedge clk);
        #1;
        bus.sample_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_busy", bus.busy, 0);
        chk("ar_data", bus.result_data, 0);
        chk("ar_full", bus.result_full, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        send(0, 8, 2, 0, "ar_post");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
